// File: rtl/logic_pkg.sv
// Shared types for the accumulated-word stream decoder.
package logic_pkg;

  typedef enum logic {
    ST_WAIT_SYNC = 1'b0,
    ST_RUN       = 1'b1
  } state_e;

  localparam int unsigned SKID_DATA_BITS = 8;

  typedef struct packed {
    logic                      first;
    logic [SKID_DATA_BITS-1:0] data;
  } skid_entry_t;

endpackage

// File: rtl/logic_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready_o is the registered skid-empty flag.
module logic_skid #(
  parameter int unsigned PAR_WIDTH = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAR_WIDTH-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAR_WIDTH-1:0] out_data_o
);

  logic                 out_valid_q, out_valid_d;
  logic [PAR_WIDTH-1:0] out_data_q, out_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [PAR_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                 accept, xfer;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign accept      = in_valid_i & ~skid_valid_q;
  assign xfer        = out_valid_q & out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (xfer) begin
      // A full skid blocks accept, so it only needs to drain here.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/logic_l2_dec.sv
// Running-sum stream decoder: sample = sum - previous sum, sync-tracked, skid-buffered output.
module logic_l2_dec
  import logic_pkg::*;
#(
  parameter int unsigned PAR_DATA_BITS = 8,
  parameter int unsigned PAR_CNT_BITS  = 16
) (
  input  logic                     ib_clk,
  input  logic                     ib_rst,
  input  logic                     ib_valid,
  input  logic                     ib_sync,
  input  logic [PAR_DATA_BITS-1:0] ivG_sum,
  output logic                     ob_ready,
  output logic                     ob_valid,
  input  logic                     ib_ready,
  output logic [PAR_DATA_BITS-1:0] ovG_data,
  output logic                     ob_first,
  output logic [PAR_CNT_BITS-1:0]  ovG_count
);

  state_e                   state_q;
  logic [PAR_DATA_BITS-1:0] prev_q;
  logic [PAR_CNT_BITS-1:0]  count_q;
  logic                     accept, dec_valid;
  logic [PAR_DATA_BITS-1:0] base, dec_data;

  assign accept    = ib_valid & ob_ready;
  assign dec_valid = accept & (ib_sync | (state_q == ST_RUN));
  // A sync word starts a new stream, so it is decoded against zero.
  assign base      = ib_sync ? '0 : prev_q;
  assign dec_data  = ivG_sum - base;
  assign ovG_count = count_q;

  always_ff @(posedge ib_clk) begin
    if (ib_rst) begin
      state_q <= ST_WAIT_SYNC;
      prev_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      if (ib_sync) begin
        state_q <= ST_RUN;
        prev_q  <= ivG_sum;
        count_q <= PAR_CNT_BITS'(1);
      end else if (state_q == ST_RUN) begin
        prev_q <= ivG_sum;
        if (count_q != '1) count_q <= count_q + PAR_CNT_BITS'(1);
      end
    end
  end

  logic_skid #(
    .PAR_WIDTH(PAR_DATA_BITS + 1)
  ) u_skid (
    .clk_i       (ib_clk),
    .rst_i       (ib_rst),
    .in_valid_i  (dec_valid),
    .in_ready_o  (ob_ready),
    .in_data_i   ({ib_sync, dec_data}),
    .out_valid_o (ob_valid),
    .out_ready_i (ib_ready),
    .out_data_o  ({ob_first, ovG_data})
  );

endmodule
